dpe_mux_scheduler: RTL and testbench

//  Weighted round-robin packet scheduler that drives the select of the 5:1 DPE stream multiplexer.

---
 rtl/dpe_mux_scheduler_if.sv | 31 +++
 rtl/dpe_mux_scheduler.sv | 138 +++++++++++++
 tb/tb_dpe_mux_scheduler.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dpe_mux_scheduler_if.sv
// Handshake bundle between the DPE mux scheduler and its surroundings:
// configuration, per-input requests, muxed-output monitor taps, pause and grant.
interface dpe_mux_scheduler_if #(
    parameter int N_PORTS  = 5,
    parameter int WEIGHT_W = 4
);
    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [N_PORTS-1:0]          cfg_en;
    logic [N_PORTS*WEIGHT_W-1:0] cfg_weight;
    logic [N_PORTS-1:0]          req;
    logic                        mon_tvalid;
    logic                        mon_tready;
    logic                        mon_tlast;
    logic                        pause;
    logic                        paused;
    logic [N_PORTS-1:0]          grant;
    logic [IDX_W-1:0]            grant_idx;
    logic                        grant_valid;
    logic                        err_oversize;

    modport master (
        output cfg_en, cfg_weight, req, mon_tvalid, mon_tready, mon_tlast, pause,
        input  paused, grant, grant_idx, grant_valid, err_oversize
    );

    modport slave (
        input  cfg_en, cfg_weight, req, mon_tvalid, mon_tready, mon_tlast, pause,
        output paused, grant, grant_idx, grant_valid, err_oversize
    );
endinterface

// File: rtl/dpe_mux_scheduler.sv
// Weighted round-robin packet scheduler for the 5:1 DPE stream mux: grants whole
// tlast-bounded packets, quiesces on pause at packet boundaries, flags runaway packets.
module dpe_mux_scheduler #(
    parameter int N_PORTS   = 5,
    parameter int WEIGHT_W  = 4,
    parameter int MAX_BEATS = 1024
) (
    input logic                clk,
    input logic                rst,
    dpe_mux_scheduler_if.slave bus
);
    localparam int IDX_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int BEAT_W = $clog2(MAX_BEATS + 2);

    localparam logic [1:0] S_RELOAD = 2'd0;
    localparam logic [1:0] S_ARB    = 2'd1;
    localparam logic [1:0] S_XFER   = 2'd2;
    localparam logic [1:0] S_PAUSED = 2'd3;

    logic [1:0]          state;
    logic [WEIGHT_W-1:0] credit [N_PORTS];
    logic [IDX_W-1:0]    ptr;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [N_PORTS-1:0]  grant_r;
    logic [IDX_W-1:0]    grant_idx_r;
    logic                paused_r;
    logic                err_r;

    logic                beat;
    logic [N_PORTS-1:0]  eligible;
    logic                any_req;
    logic [IDX_W-1:0]    scan_idx [N_PORTS];
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W-1:0]    ptr_next;

    // A zero weight still earns one packet per round.
    function automatic logic [WEIGHT_W-1:0] weight_floor1(input logic [WEIGHT_W-1:0] w);
        return (w == '0) ? WEIGHT_W'(1) : w;
    endfunction

    function automatic logic [BEAT_W-1:0] sat_inc(input logic [BEAT_W-1:0] v);
        return (v == BEAT_W'(MAX_BEATS + 1)) ? v : v + BEAT_W'(1);
    endfunction

    assign beat     = bus.mon_tvalid & bus.mon_tready;
    assign any_req  = |(bus.req & bus.cfg_en);
    assign ptr_next = (grant_idx_r == IDX_W'(N_PORTS - 1)) ? '0 : grant_idx_r + IDX_W'(1);

    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            eligible[i] = bus.req[i] & bus.cfg_en[i] & (credit[i] != '0);
        end
    end

    // Scan descends so the port closest to ptr (lowest offset) is the one kept.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            scan_idx[o] = IDX_W'((int'(ptr) + o) % N_PORTS);
        end
        for (int o = N_PORTS - 1; o >= 0; o--) begin
            if (eligible[scan_idx[o]]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx[o];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_RELOAD;
            ptr         <= '0;
            beat_cnt    <= '0;
            grant_r     <= '0;
            grant_idx_r <= '0;
            paused_r    <= 1'b0;
            err_r       <= 1'b0;
            for (int i = 0; i < N_PORTS; i++) begin
                credit[i] <= '0;
            end
        end else begin
            err_r <= 1'b0;
            case (state)
                S_RELOAD: begin
                    for (int i = 0; i < N_PORTS; i++) begin
                        credit[i] <= weight_floor1(bus.cfg_weight[i*WEIGHT_W +: WEIGHT_W]);
                    end
                    state <= bus.pause ? S_PAUSED : S_ARB;
                end
                S_ARB: begin
                    if (bus.pause) begin
                        state <= S_PAUSED;
                    end else if (pick_found) begin
                        grant_r     <= N_PORTS'(1) << pick_idx;
                        grant_idx_r <= pick_idx;
                        state       <= S_XFER;
                    end else if (any_req) begin
                        state <= S_RELOAD;
                    end
                end
                // Grant is frozen here; only the muxed handshake moves the FSM.
                S_XFER: begin
                    if (beat) begin
                        if (beat_cnt == BEAT_W'(MAX_BEATS)) begin
                            err_r <= 1'b1;
                        end
                        if (bus.mon_tlast) begin
                            credit[grant_idx_r] <= credit[grant_idx_r] - WEIGHT_W'(1);
                            ptr      <= ptr_next;
                            beat_cnt <= '0;
                            grant_r  <= '0;
                            state    <= bus.pause ? S_PAUSED : S_ARB;
                        end else begin
                            beat_cnt <= sat_inc(beat_cnt);
                        end
                    end
                end
                S_PAUSED: begin
                    if (!bus.pause) begin
                        paused_r <= 1'b0;
                        state    <= S_ARB;
                    end else begin
                        paused_r <= 1'b1;
                    end
                end
                default: state <= S_RELOAD;
            endcase
        end
    end

    assign bus.grant        = grant_r;
    assign bus.grant_idx    = grant_idx_r;
    assign bus.grant_valid  = |grant_r;
    assign bus.paused       = paused_r;
    assign bus.err_oversize = err_r;
endmodule

// File: tb/tb_dpe_mux_scheduler.sv
// Directed bench for dpe_mux_scheduler: expected grant order goes into a queue,
// a negedge monitor pops and compares on every new grant.
module tb_dpe_mux_scheduler;
    localparam int NP = 5;
    localparam int WW = 4;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dpe_mux_scheduler_if #(.N_PORTS(NP), .WEIGHT_W(WW)) bus ();
    dpe_mux_scheduler #(.N_PORTS(NP), .WEIGHT_W(WW), .MAX_BEATS(MB)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   compared   = 0;
    int   mismatched = 0;
    int   err_pulses = 0;
    int   exp_q[$];
    logic gv_prev    = 1'b0;
    logic [2:0] idx_prev = '0;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: scoreboard pop on each new grant, hold and exclusivity checks.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (bus.err_oversize === 1'b1) err_pulses++;
            if (rst) begin
                if (bus.grant_valid && !gv_prev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_grant", int'(bus.grant_idx), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("grant_idx", int'(bus.grant_idx), e);
                        check("grant_onehot", int'(bus.grant), 1 << e);
                    end
                end else if (bus.grant_valid && gv_prev) begin
                    check("grant_stable", int'(bus.grant_idx), int'(idx_prev));
                end
                check("paused_vs_grant", int'(bus.paused & bus.grant_valid), 0);
            end
            gv_prev  = bus.grant_valid;
            idx_prev = bus.grant_idx;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, int'(bus.grant), 0);
        check({tag, "_grant_idx"}, int'(bus.grant_idx), 0);
        check({tag, "_grant_valid"}, int'(bus.grant_valid), 0);
        check({tag, "_paused"}, int'(bus.paused), 0);
        check({tag, "_err"}, int'(bus.err_oversize), 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        bus.pause = 1'b0;
        bus.mon_tvalid = 1'b0;
        bus.mon_tready = 1'b0;
        bus.mon_tlast = 1'b0;
        tick();
        tick();
        check_reset_outputs(tag);
        rst = 1'b1;
    endtask

    task automatic wait_grant(output int waited);
        waited = 0;
        while (!bus.grant_valid && waited < 50) begin
            tick();
            waited++;
        end
        if (!bus.grant_valid) check("grant_timeout", 0, 1);
    endtask

    // One packet on the granted port; optional pause, 3-cycle stall, or cfg_en clear.
    task automatic packet(input int beats, input int pause_at, input int stall_at,
                          input int en_clear_at, output int waited);
        wait_grant(waited);
        if (bus.grant_valid) begin
            for (int b = 1; b <= beats; b++) begin
                if (b == pause_at) bus.pause = 1'b1;
                if (b == en_clear_at) bus.cfg_en[bus.grant_idx] = 1'b0;
                bus.mon_tvalid = 1'b1;
                bus.mon_tlast  = (b == beats);
                if (b == stall_at) begin
                    bus.mon_tready = 1'b0;
                    repeat (3) tick();
                end
                bus.mon_tready = 1'b1;
                tick();
            end
            bus.mon_tvalid = 1'b0;
            bus.mon_tlast  = 1'b0;
        end
    endtask

    initial begin
        int w;
        int e0;
        int t1_wait [6] = '{2, 1, 1, 1, 1, 3};
        int t2_port [8] = '{0, 1, 0, 0, 1, 0, 0, 0};
        int t2_wait [8] = '{2, 1, 1, 1, 3, 1, 1, 1};

        bus.cfg_en = 5'b11111;
        bus.cfg_weight = 20'h11111;
        bus.req = 5'b00000;
        bus.pause = 1'b0;
        bus.mon_tvalid = 1'b0;
        bus.mon_tready = 1'b0;
        bus.mon_tlast = 1'b0;

        // 1: equal weights, all requesting, 2-beat packets
        bus.req = 5'b11111;
        do_reset("rst1");
        for (int i = 0; i < 6; i++) exp_q.push_back(i % NP);
        for (int i = 0; i < 6; i++) begin
            packet(2, 0, 0, 0, w);
            check($sformatf("t1_wait%0d", i), w, t1_wait[i]);
        end
        bus.req = 5'b00000;

        // 2: weight 3 on port 0, ports 0 and 1 requesting
        bus.cfg_weight = 20'h11113;
        bus.req = 5'b00011;
        do_reset("rst2");
        for (int i = 0; i < 8; i++) exp_q.push_back(t2_port[i]);
        for (int i = 0; i < 8; i++) begin
            packet(1, 0, 0, 0, w);
            check($sformatf("t2_wait%0d", i), w, t2_wait[i]);
        end
        bus.req = 5'b00000;

        // 3: pause during a 6-beat packet on port 0
        bus.cfg_weight = 20'h11111;
        bus.req = 5'b00011;
        do_reset("rst3");
        e0 = err_pulses;
        exp_q.push_back(0);
        packet(6, 2, 0, 0, w);
        check("t3_gv_after_eop", int'(bus.grant_valid), 0);
        check("t3_paused_entry", int'(bus.paused), 0);
        tick();
        check("t3_paused_set", int'(bus.paused), 1);
        check("t3_gv_paused", int'(bus.grant_valid), 0);
        tick();
        tick();
        check("t3_paused_hold", int'(bus.paused), 1);
        check("t3_err_pulses", err_pulses - e0, 1);
        exp_q.push_back(1);
        bus.pause = 1'b0;
        tick();
        check("t3_paused_clr", int'(bus.paused), 0);
        packet(2, 0, 0, 0, w);
        check("t3_resume_wait", w, 1);
        bus.req = 5'b00000;

        // 4: tready stalls mid-packet freeze beat count and credit
        bus.req = 5'b00011;
        do_reset("rst4");
        e0 = err_pulses;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(0);
        packet(4, 0, 3, 0, w);
        check("t4_no_err", err_pulses - e0, 0);
        packet(2, 0, 0, 0, w);
        check("t4_wait_p1", w, 1);
        packet(1, 0, 0, 0, w);
        check("t4_wait_reload", w, 3);
        bus.req = 5'b00000;

        // 5: port 1 disabled, port 2 disabled mid-packet
        bus.cfg_en = 5'b11101;
        bus.req = 5'b00110;
        do_reset("rst5");
        exp_q.push_back(2);
        exp_q.push_back(2);
        packet(3, 0, 0, 0, w);
        check("t5_wait_first", w, 2);
        packet(3, 0, 0, 2, w);
        check("t5_wait_reload", w, 3);
        repeat (6) tick();
        check("t5_no_more_grant", int'(bus.grant_valid), 0);
        bus.req = 5'b00000;
        bus.cfg_en = 5'b11111;

        // 6: runaway packet then reset mid-packet
        bus.req = 5'b00100;
        do_reset("rst6");
        e0 = err_pulses;
        exp_q.push_back(2);
        wait_grant(w);
        for (int b = 1; b <= 6; b++) begin
            bus.mon_tvalid = 1'b1;
            bus.mon_tready = 1'b1;
            bus.mon_tlast  = 1'b0;
            tick();
            if (b == 4) check("t6_err_beat4", int'(bus.err_oversize), 0);
            if (b == 5) check("t6_err_beat5", int'(bus.err_oversize), 1);
            if (b == 6) check("t6_err_beat6", int'(bus.err_oversize), 0);
        end
        bus.mon_tvalid = 1'b0;
        check("t6_err_pulses", err_pulses - e0, 1);
        check("t6_grant_held", int'(bus.grant_idx), 2);
        rst = 1'b0;
        tick();
        check_reset_outputs("t6_midrst");
        rst = 1'b1;
        bus.req = 5'b00000;
        repeat (4) tick();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
